// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between data, fetch and host requesters.
// Optional macro ARB_HOST_LOCK_EN: host_lock restricts arbitration to requester 2.
module mem_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   input  logic                  host_lock,
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t              state_q;
   logic [1:0]          last_q;
   logic [1:0]          cur_q;
   logic [1:0]          cnt_q;
   logic [2:0]          gnt_q;
   logic [2:0]          rvalid_q;
   logic                busy_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_we_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W-1:0]   rdata_q;

   logic [2:0]          req_eff;
   logic [1:0]          p0, p1, p2;
   logic                win_found;
   logic [1:0]          win_idx;
   logic [2:0]          gnt_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                we_d;

`ifdef ARB_HOST_LOCK_EN
   assign req_eff = host_lock ? (req & 3'b100) : req;
`else
   logic unused_host_lock;
   assign unused_host_lock = host_lock;
   assign req_eff = req;
`endif

   // Scan order starts just after the last winner so every requester waits at most two others.
   always_comb begin
      case (last_q)
         2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      win_found = |req_eff;
      if (req_eff[p0]) begin
         win_idx = p0;
      end else if (req_eff[p1]) begin
         win_idx = p1;
      end else begin
         win_idx = p2;
      end
   end

   always_comb begin
      gnt_d   = 3'b000;
      addr_d  = '0;
      wdata_d = '0;
      we_d    = 1'b0;
      case (win_idx)
         2'd0: begin
            gnt_d   = 3'b001;
            addr_d  = addr[0*ADDR_W +: ADDR_W];
            wdata_d = wdata[0*DATA_W +: DATA_W];
            we_d    = we[0];
         end
         2'd1: begin
            gnt_d   = 3'b010;
            addr_d  = addr[1*ADDR_W +: ADDR_W];
            wdata_d = wdata[1*DATA_W +: DATA_W];
            we_d    = we[1];
         end
         default: begin
            gnt_d   = 3'b100;
            addr_d  = addr[2*ADDR_W +: ADDR_W];
            wdata_d = wdata[2*DATA_W +: DATA_W];
            we_d    = we[2];
         end
      endcase
   end

   // Grant, write strobe and read-valid are one-cycle pulses cleared by default every cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 2'd2;
         cur_q       <= 2'd0;
         cnt_q       <= 2'd0;
         gnt_q       <= 3'b000;
         rvalid_q    <= 3'b000;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         gnt_q    <= 3'b000;
         rvalid_q <= 3'b000;
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  cur_q       <= win_idx;
                  last_q      <= win_idx;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= wdata_d;
                  mem_we_q    <= we_d;
                  gnt_q       <= gnt_d;
                  busy_q      <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_we_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= 2'(READ_LAT - 1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 2'd0) begin
                  rdata_q  <= mem_rdata;
                  rvalid_q <= 3'b001 << cur_q;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; three instances cover read latencies 1, 3 and 4.
module tb_mem_port_arbiter;

`ifdef ARB_HOST_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    req = 3'b000;
   logic [2:0]    we = 3'b000;
   logic [29:0]   addr = '0;
   logic [95:0]   wdata = '0;
   logic          hostLock = 1'b0;
   logic [31:0]   memRdata = 32'hDEADBEEF;

   logic [2:0]  gnt1, rvalid1, gnt3, rvalid3, gnt4, rvalid4;
   logic [31:0] rdata1, rdata3, rdata4;
   logic        busy1, busy3, busy4;
   logic [9:0]  memAddr1, memAddr3, memAddr4;
   logic        memWe1, memWe3, memWe4;
   logic [31:0] memWdata1, memWdata3, memWdata4;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1)) u_lat1 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .host_lock(hostLock), .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .busy(busy1),
      .mem_addr(memAddr1), .mem_we(memWe1), .mem_wdata(memWdata1), .mem_rdata(memRdata));

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(3)) u_lat3 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .host_lock(hostLock), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3),
      .mem_addr(memAddr3), .mem_we(memWe3), .mem_wdata(memWdata3), .mem_rdata(memRdata));

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(4)) u_lat4 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .host_lock(hostLock), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .busy(busy4),
      .mem_addr(memAddr4), .mem_we(memWe4), .mem_wdata(memWdata4), .mem_rdata(memRdata));

   // Leaves the bench on a falling edge with reset just released and all requests low.
   task automatic doReset();
      @(negedge clock);
      reset = 1'b0;
      req = 3'b000;
      we = 3'b000;
      hostLock = 1'b0;
      memRdata = 32'hDEADBEEF;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic       found;
      logic [2:0] got;
      @(negedge clock);
      reset = 1'b0;
      req = 3'b111;
      we = 3'b000;
      repeat (3) @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_gnt got %b expected 000", gnt1); end
      testsRun++;
      if (rvalid1 !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_rvalid got %b expected 000", rvalid1); end
      testsRun++;
      if (memWe1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem_we got %b expected 0", memWe1); end
      testsRun++;
      if (busy1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b expected 0", busy1); end
      testsRun++;
      if (memAddr1 !== 10'h000 || rdata1 !== 32'h0 || memWdata1 !== 32'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_data got addr=%h rdata=%h wdata=%h expected zeros", memAddr1, rdata1, memWdata1);
      end
      reset = 1'b1;
      found = 1'b0;
      got = 3'b000;
      for (int c = 0; c < 4 && !found; c++) begin
         @(negedge clock);
         if (gnt1 !== 3'b000) begin found = 1'b1; got = gnt1; end
      end
      testsRun++;
      if (!found || got !== 3'b001) begin
         testsFailed++;
         $display("[TB] FAIL reset_first_gnt got %b (seen=%b) expected 001", got, found);
      end
   endtask

   task automatic test_single_read();
      doReset();
      addr[10 +: 10] = 10'h07F;
      req = 3'b010;
      we = 3'b000;
      @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b010 || memAddr1 !== 10'h07F || memWe1 !== 1'b0 || busy1 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL read_issue got gnt=%b addr=%h we=%b busy=%b expected gnt=010 addr=07f we=0 busy=1",
                  gnt1, memAddr1, memWe1, busy1);
      end
      req = 3'b000;
      @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b000 || rvalid1 !== 3'b000 || busy1 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL read_wait got gnt=%b rvalid=%b busy=%b expected 000 000 1", gnt1, rvalid1, busy1);
      end
      memRdata = 32'hCAFE0001;
      @(negedge clock);
      testsRun++;
      if (rvalid1 !== 3'b010 || rdata1 !== 32'hCAFE0001 || busy1 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL read_data got rvalid=%b rdata=%h busy=%b expected 010 cafe0001 0", rvalid1, rdata1, busy1);
      end
      memRdata = 32'hDEADBEEF;
      @(negedge clock);
      testsRun++;
      if (rvalid1 !== 3'b000 || rdata1 !== 32'hCAFE0001) begin
         testsFailed++;
         $display("[TB] FAIL read_hold got rvalid=%b rdata=%h expected 000 cafe0001", rvalid1, rdata1);
      end
   endtask

   task automatic test_single_write();
      doReset();
      addr[0 +: 10] = 10'h3FF;
      wdata[0 +: 32] = 32'h12345678;
      req = 3'b001;
      we = 3'b001;
      @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b001 || memWe1 !== 1'b1 || memAddr1 !== 10'h3FF || memWdata1 !== 32'h12345678) begin
         testsFailed++;
         $display("[TB] FAIL write_issue got gnt=%b we=%b addr=%h wdata=%h expected 001 1 3ff 12345678",
                  gnt1, memWe1, memAddr1, memWdata1);
      end
      req = 3'b000;
      we = 3'b000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         testsRun++;
         if (memWe1 !== 1'b0 || gnt1 !== 3'b000 || rvalid1 !== 3'b000 || busy1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_after c=%0d got we=%b gnt=%b rvalid=%b busy=%b expected 0 000 000 0",
                     c, memWe1, gnt1, rvalid1, busy1);
         end
      end
   endtask

   task automatic test_back_to_back();
      doReset();
      addr[0 +: 10] = 10'h011;
      addr[20 +: 10] = 10'h222;
      wdata[0 +: 32] = 32'hA0A0A0A0;
      wdata[64 +: 32] = 32'hC2C2C2C2;
      req = 3'b101;
      we = 3'b101;
      @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b001 || memWe1 !== 1'b1 || memAddr1 !== 10'h011 || memWdata1 !== 32'hA0A0A0A0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_first got gnt=%b we=%b addr=%h wdata=%h expected 001 1 011 a0a0a0a0",
                  gnt1, memWe1, memAddr1, memWdata1);
      end
      req = 3'b100;
      @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b000 || memWe1 !== 1'b0 || busy1 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_gap got gnt=%b we=%b busy=%b expected 000 0 0", gnt1, memWe1, busy1);
      end
      @(negedge clock);
      testsRun++;
      if (gnt1 !== 3'b100 || memWe1 !== 1'b1 || memAddr1 !== 10'h222 || memWdata1 !== 32'hC2C2C2C2) begin
         testsFailed++;
         $display("[TB] FAIL b2b_second got gnt=%b we=%b addr=%h wdata=%h expected 100 1 222 c2c2c2c2",
                  gnt1, memWe1, memAddr1, memWdata1);
      end
      req = 3'b000;
      we = 3'b000;
   endtask

   task automatic test_fairness();
      int k, r;
      logic [2:0] expG, expV;
      logic       expB;
      doReset();
      addr = {10'h102, 10'h101, 10'h100};
      req = 3'b111;
      we = 3'b000;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clock);
         k = (c - 1) / 5;
         r = (c - 1) % 5;
         expG = (r == 0) ? (3'b001 << (k % 3)) : 3'b000;
         expV = (r == 4) ? (3'b001 << (k % 3)) : 3'b000;
         expB = (r != 4);
         testsRun++;
         if (gnt3 !== expG || rvalid3 !== expV || busy3 !== expB) begin
            testsFailed++;
            $display("[TB] FAIL fair c=%0d got gnt=%b rvalid=%b busy=%b expected %b %b %b",
                     c, gnt3, rvalid3, busy3, expG, expV, expB);
         end
      end
      req = 3'b000;
   endtask

   task automatic test_mid_read_reset();
      doReset();
      addr[10 +: 10] = 10'h155;
      req = 3'b010;
      we = 3'b000;
      @(negedge clock);
      testsRun++;
      if (gnt4 !== 3'b010) begin testsFailed++; $display("[TB] FAIL midrst_gnt got %b expected 010", gnt4); end
      req = 3'b000;
      @(negedge clock);
      testsRun++;
      if (busy4 !== 1'b1 || memAddr4 !== 10'h155) begin
         testsFailed++;
         $display("[TB] FAIL midrst_wait got busy=%b addr=%h expected 1 155", busy4, memAddr4);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      testsRun++;
      if (busy4 !== 1'b0 || gnt4 !== 3'b000 || rvalid4 !== 3'b000 || memAddr4 !== 10'h000 || memWe4 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midrst_clear got busy=%b gnt=%b rvalid=%b addr=%h we=%b expected 0 000 000 000 0",
                  busy4, gnt4, rvalid4, memAddr4, memWe4);
      end
      @(negedge clock);
      testsRun++;
      if (rvalid4 !== 3'b000) begin testsFailed++; $display("[TB] FAIL midrst_rvalid1 got %b expected 000", rvalid4); end
      reset = 1'b1;
      req = 3'b011;
      @(negedge clock);
      testsRun++;
      if (gnt4 !== 3'b001 || rvalid4 !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL midrst_next got gnt=%b rvalid=%b expected 001 000", gnt4, rvalid4);
      end
      req = 3'b000;
   endtask

   task automatic test_host_lock();
      logic [2:0] expSeq [5];
      logic [2:0] expG, expNext;
      int k, r;
      if (LockEn) begin
         expSeq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
         expNext = 3'b001;
      end else begin
         expSeq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
         expNext = 3'b100;
      end
      doReset();
      hostLock = 1'b1;
      req = 3'b111;
      we = 3'b000;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clock);
         k = (c - 1) / 3;
         r = (c - 1) % 3;
         expG = (r == 0) ? expSeq[k] : 3'b000;
         testsRun++;
         if (gnt1 !== expG) begin
            testsFailed++;
            $display("[TB] FAIL lock_gnt c=%0d got %b expected %b", c, gnt1, expG);
         end
      end
      hostLock = 1'b0;
      @(negedge clock);
      testsRun++;
      if (gnt1 !== expNext) begin
         testsFailed++;
         $display("[TB] FAIL lock_release got %b expected %b", gnt1, expNext);
      end
      req = 3'b000;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_back_to_back();
      test_fairness();
      test_mid_read_reset();
      test_host_lock();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
